// File: rtl/uart_pkg.sv
// Shared UART definitions: baud select encoding, baud rate table, bit-period helper
// and the auto-baud FSM state type.
package uart_pkg;

    typedef enum logic [2:0] {
        BAUD_4800,
        BAUD_9600,
        BAUD_14400,
        BAUD_19200,
        BAUD_38400,
        BAUD_57600,
        BAUD_115200,
        BAUD_230400
    } baud_sel_t;

    localparam int unsigned BAUD_RATE [8] = '{
        4800, 9600, 14400, 19200, 38400, 57600, 115200, 230400
    };

    typedef enum logic [2:0] {
        StIdle,
        StWaitFall,
        StMeasure,
        StEval,
        StApply,
        StError
    } autobaud_state_t;

    function automatic int unsigned bit_period(input int unsigned sys_freq,
                                               input baud_sel_t   sel);
        return sys_freq / BAUD_RATE[int'(sel)];
    endfunction

endpackage

// File: rtl/uart_line_sync.sv
// RX pin synchronizer with falling-edge pulse output. Defining AUTOBAUD_GLITCH_FILTER_EN
// inserts a 3-sample run filter (2 extra cycles of edge latency, rejects pulses <= 2 cycles).
module uart_line_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic i_rxd,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Idle line is high; resetting to 1 avoids a spurious edge after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_rxd;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

`ifdef AUTOBAUD_GLITCH_FILTER_EN
    logic r_hist;
    logic r_filt;
    logic w_filt_next;

    always_comb begin
        w_filt_next = r_filt;
        if ((r_sync == r_prev) && (r_prev == r_hist)) begin
            w_filt_next = r_sync;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hist <= 1'b1;
            r_filt <= 1'b1;
        end else begin
            r_hist <= r_prev;
            r_filt <= w_filt_next;
        end
    end

    assign o_fall = r_filt & ~w_filt_next;
`else
    assign o_fall = r_prev & ~r_sync;
`endif

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// Baud select controller: manual select or auto-baud measurement of a 0x55 sync frame,
// applied only while TX and RX are idle. Optional macro: AUTOBAUD_GLITCH_FILTER_EN.
module uart_autobaud_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned SYSTEM_FREQUENCY = 100000000,
    parameter int unsigned SYNC_FALLS       = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rxd_i,
    input  logic       auto_en_i,
    input  logic       start_i,
    input  logic [2:0] manual_sl_i,
    input  logic       tx_busy_i,
    input  logic       rx_busy_i,
    output logic [2:0] baud_sl_o,
    output logic       locked_o,
    output logic       err_o,
    output logic       busy_o
);

    localparam int unsigned P0 = bit_period(SYSTEM_FREQUENCY, BAUD_4800);
    localparam int unsigned P1 = bit_period(SYSTEM_FREQUENCY, BAUD_9600);
    localparam int unsigned P2 = bit_period(SYSTEM_FREQUENCY, BAUD_14400);
    localparam int unsigned P3 = bit_period(SYSTEM_FREQUENCY, BAUD_19200);
    localparam int unsigned P4 = bit_period(SYSTEM_FREQUENCY, BAUD_38400);
    localparam int unsigned P5 = bit_period(SYSTEM_FREQUENCY, BAUD_57600);
    localparam int unsigned P6 = bit_period(SYSTEM_FREQUENCY, BAUD_115200);
    localparam int unsigned P7 = bit_period(SYSTEM_FREQUENCY, BAUD_230400);

    localparam int unsigned SPAN_LIMIT = 16 * P0;
    localparam int unsigned M_MAX      = 2 * P0;
    localparam int unsigned M_MIN      = P7 / 2;
    localparam int unsigned MID [7]    = '{
        (P0 + P1) / 2, (P1 + P2) / 2, (P2 + P3) / 2, (P3 + P4) / 2,
        (P4 + P5) / 2, (P5 + P6) / 2, (P6 + P7) / 2
    };

    autobaud_state_t r_state;
    baud_sel_t       r_baud_sl;
    baud_sel_t       r_pend_sl;
    logic [31:0]     r_span;
    logic [7:0]      r_fall_cnt;
    logic            r_locked;
    logic            r_err;

    logic            w_fall;
    logic [31:0]     w_m;
    logic            w_range_err;
    baud_sel_t       w_sel;

    uart_line_sync u_line_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_rxd   (rxd_i),
        .o_fall  (w_fall)
    );

    // First-to-last fall span covers 8 bit times, so M is one bit period.
    always_comb begin
        w_m         = {3'b000, r_span[31:3]};
        w_range_err = (w_m > M_MAX) || (w_m < M_MIN);
        w_sel       = BAUD_230400;
        for (int i = 6; i >= 0; i--) begin
            if (w_m > MID[i]) begin
                w_sel = baud_sel_t'(3'(i));
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_baud_sl  <= BAUD_115200;
            r_pend_sl  <= BAUD_4800;
            r_span     <= '0;
            r_fall_cnt <= '0;
            r_locked   <= 1'b0;
            r_err      <= 1'b0;
        end else if ((r_state != StIdle) && !auto_en_i) begin
            r_state  <= StIdle;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (auto_en_i) begin
                        if (start_i) begin
                            r_err    <= 1'b0;
                            r_locked <= 1'b0;
                            r_state  <= StWaitFall;
                        end
                    end else if ((manual_sl_i != r_baud_sl) && !tx_busy_i && !rx_busy_i) begin
                        r_baud_sl <= baud_sel_t'(manual_sl_i);
                        r_locked  <= 1'b0;
                    end
                end
                StWaitFall: begin
                    if (w_fall) begin
                        r_span     <= '0;
                        r_fall_cnt <= 8'd1;
                        r_state    <= StMeasure;
                    end
                end
                StMeasure: begin
                    if (r_span != '1) begin
                        r_span <= r_span + 32'd1;
                    end
                    if (r_span > SPAN_LIMIT) begin
                        r_state <= StError;
                    end else if (w_fall) begin
                        r_fall_cnt <= r_fall_cnt + 8'd1;
                        if ((r_fall_cnt + 8'd1) == 8'(SYNC_FALLS)) begin
                            r_state <= StEval;
                        end
                    end
                end
                StEval: begin
                    if (w_range_err) begin
                        r_state <= StError;
                    end else begin
                        r_pend_sl <= w_sel;
                        r_state   <= StApply;
                    end
                end
                StApply: begin
                    if (!tx_busy_i && !rx_busy_i) begin
                        r_baud_sl <= r_pend_sl;
                        r_locked  <= 1'b1;
                        r_state   <= StIdle;
                    end
                end
                StError: begin
                    r_err   <= 1'b1;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign baud_sl_o = r_baud_sl;
    assign locked_o  = r_locked;
    assign err_o     = r_err;
    assign busy_o    = (r_state != StIdle);

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Directed bench for uart_autobaud_ctrl, run at SYSTEM_FREQUENCY = 10 MHz so the
// timeout case stays short. Bit periods: 9600=1041, 38400=260, 115200=86 cycles.
module tb_uart_autobaud_ctrl;

    logic       clk;
    logic       reset_n;
    logic       rxd_i;
    logic       auto_en_i;
    logic       start_i;
    logic [2:0] manual_sl_i;
    logic       tx_busy_i;
    logic       rx_busy_i;
    logic [2:0] baud_sl_o;
    logic       locked_o;
    logic       err_o;
    logic       busy_o;

    int n_cmp;
    int n_err;
    logic [2:0] exp_glitch_sl;

    uart_autobaud_ctrl #(
        .SYSTEM_FREQUENCY (10000000),
        .SYNC_FALLS       (5)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rxd_i       (rxd_i),
        .auto_en_i   (auto_en_i),
        .start_i     (start_i),
        .manual_sl_i (manual_sl_i),
        .tx_busy_i   (tx_busy_i),
        .rx_busy_i   (rx_busy_i),
        .baud_sl_o   (baud_sl_o),
        .locked_o    (locked_o),
        .err_o       (err_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // 0x55 frame, LSB first; a cycle offset equal to g0 or g1 is forced low.
    task automatic send_frame(input int bit_cyc, input int g0, input int g1);
        logic [9:0] bits;
        bits = {1'b1, 8'h55, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < bit_cyc; c++) begin
                rxd_i = bits[b];
                if ((b * bit_cyc + c == g0) || (b * bit_cyc + c == g1)) rxd_i = 1'b0;
                tick();
            end
        end
        rxd_i = 1'b1;
        repeat (20) tick();
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        int n;
        n = 0;
        while (busy_o && (n < max_cyc)) begin
            tick();
            n++;
        end
        check(tag, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        reset_n     = 1'b0;
        rxd_i       = 1'b1;
        auto_en_i   = 1'b0;
        start_i     = 1'b0;
        manual_sl_i = 3'b110;
        tx_busy_i   = 1'b0;
        rx_busy_i   = 1'b0;
        repeat (3) tick();
        check("rst_baud", baud_sl_o, 3'b110);
        check("rst_locked", locked_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        reset_n = 1'b1;
        tick();

        // Manual change held off while TX busy
        tx_busy_i   = 1'b1;
        manual_sl_i = 3'b001;
        repeat (50) tick();
        check("man_hold", baud_sl_o, 3'b110);
        tx_busy_i = 1'b0;
        check("man_hold_edge", baud_sl_o, 3'b110);
        tick();
        check("man_apply", baud_sl_o, 3'b001);
        check("man_locked", locked_o, 1'b0);

        // start ignored in manual mode
        pulse_start();
        check("man_start_ignored", busy_o, 1'b0);

        // Auto 115200: M = 86 -> index 6
        auto_en_i = 1'b1;
        pulse_start();
        check("a115_busy", busy_o, 1'b1);
        send_frame(86, -1, -1);
        wait_idle(200, "a115_idle");
        check("a115_baud", baud_sl_o, 3'b110);
        check("a115_locked", locked_o, 1'b1);
        check("a115_err", err_o, 1'b0);

        // Auto 9600 with RX busy: result parked in APPLY
        rx_busy_i = 1'b1;
        pulse_start();
        check("a96_locked_clr", locked_o, 1'b0);
        send_frame(1041, -1, -1);
        repeat (100) tick();
        check("a96_apply_wait", busy_o, 1'b1);
        check("a96_baud_hold", baud_sl_o, 3'b110);
        rx_busy_i = 1'b0;
        tick();
        check("a96_baud", baud_sl_o, 3'b001);
        check("a96_locked", locked_o, 1'b1);
        check("a96_busy", busy_o, 1'b0);

        // Timeout: one fall then line stuck low, limit 16*2083 = 33328
        pulse_start();
        rxd_i = 1'b0;
        repeat (33000) tick();
        check("to_early_err", err_o, 1'b0);
        check("to_early_busy", busy_o, 1'b1);
        wait_idle(1000, "to_idle");
        check("to_err", err_o, 1'b1);
        check("to_baud", baud_sl_o, 3'b001);
        check("to_locked", locked_o, 1'b0);
        rxd_i = 1'b1;
        repeat (10) tick();

        // 1 Mbaud: M = 10 < 21 -> error
        pulse_start();
        check("fast_err_clr", err_o, 1'b0);
        send_frame(10, -1, -1);
        wait_idle(200, "fast_idle");
        check("fast_err", err_o, 1'b1);
        check("fast_locked", locked_o, 1'b0);
        check("fast_baud", baud_sl_o, 3'b001);

        // 38400 with 1-cycle low glitches mid D0 and mid D4
        pulse_start();
        send_frame(260, 390, 1430);
        wait_idle(200, "gl_idle");
`ifdef AUTOBAUD_GLITCH_FILTER_EN
        exp_glitch_sl = 3'b100;
        check("gl_filt_baud", baud_sl_o, 3'b100);
        check("gl_filt_err", err_o, 1'b0);
`else
        // Unfiltered the glitches count as falls: span 1430, M = 178 -> index 5
        exp_glitch_sl = 3'b101;
        if (err_o) $display("note: unfiltered glitch frame ended in error");
        else $display("note: unfiltered glitch frame gave index %0d", baud_sl_o);
        check("gl_nofilt_baud", baud_sl_o, 3'b101);
        check("gl_nofilt_err", err_o, 1'b0);
`endif

        // Abort by dropping auto mode mid-measurement
        pulse_start();
        check("ab_busy", busy_o, 1'b1);
        auto_en_i = 1'b0;
        manual_sl_i = exp_glitch_sl;
        tick();
        check("ab_idle", busy_o, 1'b0);
        check("ab_locked", locked_o, 1'b0);
        check("ab_err", err_o, 1'b0);
        check("ab_baud", baud_sl_o, exp_glitch_sl);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
